// File: rtl/dvbc_pkg.sv
// Shared constants, state type and the 8-step PRBS helper for the DVB-C
// energy-dispersal randomizer.
package dvbc_pkg;

    localparam logic [7:0]  SYNC_BYTE     = 8'h47;
    localparam logic [7:0]  INV_SYNC_BYTE = 8'hB8;
    // Bit 0 holds register stage 1, bit 14 holds stage 15.
    localparam logic [14:0] PRBS_INIT     = 15'b000000010101001;
    localparam int          PACK_LEN      = 204;
    localparam int          DATA_LEN      = 188;
    localparam int          GROUP_LEN     = 8;

    typedef enum logic {SEARCH, LOCKED} state_t;

    typedef struct packed {
        logic [14:0] nextState;
        logic [7:0]  outByte;
    } prbsStep_t;

    // Eight steps of 1+x^14+x^15; the first feedback bit lands in the byte MSB.
    function automatic prbsStep_t prbsStep8(input logic [14:0] cur);
        prbsStep_t  res;
        logic [14:0] s;
        logic        fb;
        s = cur;
        res.outByte = '0;
        for (int i = 0; i < 8; i++) begin
            fb = s[13] ^ s[14];
            s = {s[13:0], fb};
            res.outByte = {res.outByte[6:0], fb};
        end
        res.nextState = s;
        return res;
    endfunction

endpackage

// File: rtl/dvbc_prbs15.sv
// 15-stage PRBS register producing one scrambling byte per advance.
module dvbc_prbs15 (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iLoad,
    input  logic       iAdvance,
    output logic [7:0] oPrbsByte
);
    import dvbc_pkg::*;

    logic [14:0] prbsReg;
    prbsStep_t   stepNow;

    assign stepNow   = prbsStep8(prbsReg);
    assign oPrbsByte = stepNow.outByte;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            prbsReg <= PRBS_INIT;
        end else if (iLoad) begin
            prbsReg <= PRBS_INIT;
        end else if (iAdvance) begin
            prbsReg <= stepNow.nextState;
        end
    end

endmodule

// File: rtl/energy_dispersal.sv
// DVB-C energy-dispersal randomizer: frame alignment, 8-packet grouping,
// sync inversion and PRBS scrambling of TS payload bytes.
module energy_dispersal #(
    parameter int PACK_LEN  = dvbc_pkg::PACK_LEN,
    parameter int DATA_LEN  = dvbc_pkg::DATA_LEN,
    parameter int GROUP_LEN = dvbc_pkg::GROUP_LEN
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [7:0] iData,
    input  logic       iPSync,
    input  logic       iValid,
    input  logic       iBypass,
    output logic [7:0] oData,
    output logic       oPSync,
    output logic       oValid,
    output logic       oGroupStart,
    output logic       oLocked,
    output logic       oSyncErr
);
    import dvbc_pkg::*;

    localparam int BYTE_W = $clog2(PACK_LEN);
    localparam int PKT_W  = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PACK_LEN - 1);
    localparam logic [BYTE_W-1:0] DATA_END  = BYTE_W'(DATA_LEN);
    localparam logic [PKT_W-1:0]  PKT_LAST  = PKT_W'(GROUP_LEN - 1);

    state_t            stateReg, stateNext;
    logic [BYTE_W-1:0] byteCntReg, byteCntNext;
    logic [PKT_W-1:0]  pktCntReg, pktCntNext;
    logic [7:0]        dataNext;
    logic [7:0]        prbsByte;
    logic              prbsLoad, prbsAdvance;
    logic              groupStartNext, syncErrNext;
    logic              atStart, restart;

    dvbc_prbs15 uPrbs (
        .iClk      (iClk),
        .iRst      (iRst),
        .iLoad     (prbsLoad),
        .iAdvance  (prbsAdvance),
        .oPrbsByte (prbsByte)
    );

    assign atStart = (byteCntReg == '0);
    assign oLocked = (stateReg == LOCKED);

    always_comb begin
        stateNext      = stateReg;
        byteCntNext    = byteCntReg;
        pktCntNext     = pktCntReg;
        dataNext       = iData;
        prbsLoad       = 1'b0;
        prbsAdvance    = 1'b0;
        groupStartNext = 1'b0;
        syncErrNext    = 1'b0;
        restart        = 1'b0;
        if (iValid) begin
            case (stateReg)
                SEARCH: restart = iPSync;
                LOCKED: begin
                    if (iPSync != atStart) begin
                        // A stray sync realigns; a missing sync loses lock.
                        syncErrNext = 1'b1;
                        if (iPSync) begin
                            restart = 1'b1;
                        end else begin
                            stateNext   = SEARCH;
                            byteCntNext = '0;
                            pktCntNext  = '0;
                        end
                    end else if (atStart && pktCntReg == '0) begin
                        restart = 1'b1;
                    end else begin
                        // Non-inverted sync bytes still consume one PRBS byte.
                        if (atStart) begin
                            prbsAdvance = 1'b1;
                        end else if (byteCntReg < DATA_END) begin
                            dataNext    = iData ^ prbsByte;
                            prbsAdvance = 1'b1;
                        end
                        if (byteCntReg == BYTE_LAST) begin
                            byteCntNext = '0;
                            pktCntNext  = (pktCntReg == PKT_LAST) ? '0 : pktCntReg + 1'b1;
                        end else begin
                            byteCntNext = byteCntReg + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            if (restart) begin
                stateNext      = LOCKED;
                byteCntNext    = BYTE_W'(1);
                pktCntNext     = '0;
                prbsLoad       = 1'b1;
                groupStartNext = 1'b1;
                dataNext       = ~iData;
            end
            if (iBypass) begin
                dataNext = iData;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            stateReg    <= SEARCH;
            byteCntReg  <= '0;
            pktCntReg   <= '0;
            oData       <= '0;
            oPSync      <= 1'b0;
            oValid      <= 1'b0;
            oGroupStart <= 1'b0;
            oSyncErr    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            byteCntReg  <= byteCntNext;
            pktCntReg   <= pktCntNext;
            oPSync      <= iPSync;
            oValid      <= iValid;
            oGroupStart <= groupStartNext;
            oSyncErr    <= syncErrNext;
            if (iValid) begin
                oData <= dataNext;
            end
        end
    end

endmodule

// File: tb/tb_energy_dispersal.sv
// Directed bench for energy_dispersal; a second instance derandomizes the output.
module tb_energy_dispersal;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [7:0] iData;
    logic       iPSync, iValid, iBypass;
    logic [7:0] oData;
    logic       oPSync, oValid, oGroupStart, oLocked, oSyncErr;
    logic [7:0] rtData;
    logic       rtPSync, rtValid, rtGroupStart, rtLocked, rtSyncErr;

    always #5 iClk = ~iClk;

    energy_dispersal dut (
        .iClk(iClk), .iRst(iRst), .iData(iData), .iPSync(iPSync),
        .iValid(iValid), .iBypass(iBypass), .oData(oData), .oPSync(oPSync),
        .oValid(oValid), .oGroupStart(oGroupStart), .oLocked(oLocked),
        .oSyncErr(oSyncErr)
    );

    energy_dispersal rtInst (
        .iClk(iClk), .iRst(iRst), .iData(oData), .iPSync(oPSync),
        .iValid(oValid), .iBypass(1'b0), .oData(rtData), .oPSync(rtPSync),
        .oValid(rtValid), .oGroupStart(rtGroupStart), .oLocked(rtLocked),
        .oSyncErr(rtSyncErr)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       ps;
        logic       gs;
        logic       err;
        logic       lk;
    } rec_t;

    rec_t       outQ[$];
    rec_t       goldQ[$];
    logic [7:0] inQ[$];
    logic [7:0] rtQ[$];
    int         checkCnt = 0;
    int         errCnt   = 0;
    bit         gapMode  = 1'b0;

    always @(negedge iClk) begin
        if (oValid) outQ.push_back('{oData, oPSync, oGroupStart, oSyncErr, oLocked});
        if (rtValid) rtQ.push_back(rtData);
    end

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] frameByte(input int b, input logic [7:0] pay);
        if (b == 0) return 8'h47;
        if (b < 188) return pay;
        return 8'hFF;
    endfunction

    task automatic sendByte(input logic [7:0] d, input logic ps);
        int n;
        iData  = d;
        iPSync = ps;
        iValid = 1'b1;
        inQ.push_back(d);
        @(posedge iClk); #1;
        iValid = 1'b0;
        iPSync = 1'b0;
        if (gapMode) begin
            n = $urandom_range(0, 2);
            repeat (n) begin
                @(posedge iClk); #1;
            end
        end
    endtask

    task automatic sendPacket(input bit rnd);
        for (int b = 0; b < 204; b++)
            sendByte(frameByte(b, rnd ? 8'($urandom) : 8'h00), b == 0);
    endtask

    task automatic resetAll();
        iRst = 1'b1; iValid = 1'b0; iPSync = 1'b0; iBypass = 1'b0; iData = 8'h00;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        outQ.delete(); rtQ.delete(); inQ.delete();
    endtask

    task automatic flush();
        repeat (4) @(posedge iClk);
        #1;
    endtask

    int bad, cnt;

    initial begin
        // Reset with live input: everything must read zero.
        iRst = 1'b1; iValid = 1'b1; iPSync = 1'b1; iData = 8'h47; iBypass = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        checkVal("rst_oData", 32'(oData), 0);
        checkVal("rst_oValid", 32'(oValid), 0);
        checkVal("rst_oPSync", 32'(oPSync), 0);
        checkVal("rst_oGroupStart", 32'(oGroupStart), 0);
        checkVal("rst_oLocked", 32'(oLocked), 0);
        checkVal("rst_oSyncErr", 32'(oSyncErr), 0);

        // 16 packets of zero payload, gapless.
        resetAll();
        for (int p = 0; p < 16; p++) sendPacket(1'b0);
        flush();
        checkVal("zero_count", 32'(outQ.size()), 16 * 204);
        checkVal("zero_b0", 32'(outQ[0].d), 32'h B8);
        checkVal("zero_b0_gs", 32'(outQ[0].gs), 1);
        checkVal("zero_b0_lock", 32'(outQ[0].lk), 1);
        checkVal("zero_b1", 32'(outQ[1].d), 32'h03);
        checkVal("zero_b2", 32'(outQ[2].d), 32'hF6);
        bad = 0;
        for (int i = 188; i < 204; i++) if (outQ[i].d !== 8'hFF) bad++;
        checkVal("zero_stuffing_nonFF", 32'(bad), 0);
        checkVal("zero_p1_sync", 32'(outQ[204].d), 32'h47);
        checkVal("zero_p1_gs", 32'(outQ[204].gs), 0);
        checkVal("zero_p8_sync", 32'(outQ[8*204].d), 32'hB8);
        checkVal("zero_p8_gs", 32'(outQ[8*204].gs), 1);
        checkVal("zero_p8_b1", 32'(outQ[8*204+1].d), 32'h03);
        checkVal("zero_p8_b2", 32'(outQ[8*204+2].d), 32'hF6);
        cnt = 0; bad = 0;
        foreach (outQ[i]) begin
            if (outQ[i].gs) cnt++;
            if (outQ[i].err) bad++;
        end
        checkVal("zero_gs_count", 32'(cnt), 2);
        checkVal("zero_err_count", 32'(bad), 0);
        goldQ = outQ;

        // Round trip with random payload through the second instance.
        resetAll();
        for (int p = 0; p < 8; p++) sendPacket(1'b1);
        flush();
        checkVal("rt_count", 32'(rtQ.size()), 32'(inQ.size()));
        bad = 0; cnt = 0;
        foreach (inQ[i]) begin
            if (rtQ[i] !== inQ[i]) bad++;
            if (outQ[i].d !== inQ[i]) cnt++;
        end
        checkVal("rt_mismatches", 32'(bad), 0);
        checkVal("rt_scrambled", 32'(cnt != 0), 1);
        checkVal("rt_sync0", 32'(rtQ[0]), 32'h47);

        // Same zero run with random gaps must match the gapless output.
        resetAll();
        gapMode = 1'b1;
        for (int p = 0; p < 16; p++) sendPacket(1'b0);
        gapMode = 1'b0;
        flush();
        checkVal("gap_count", 32'(outQ.size()), 32'(goldQ.size()));
        bad = 0;
        foreach (goldQ[i]) if (outQ[i] !== goldQ[i]) bad++;
        checkVal("gap_stream_mismatches", 32'(bad), 0);

        // Early sync realigns, missing sync drops lock, next sync relocks.
        resetAll();
        sendByte(8'h47, 1'b1);
        for (int i = 1; i < 100; i++) sendByte(8'h00, 1'b0);
        sendByte(8'h47, 1'b1);
        for (int b = 1; b < 204; b++) sendByte(frameByte(b, 8'h00), 1'b0);
        sendByte(8'h47, 1'b0);
        for (int i = 0; i < 5; i++) sendByte(8'h00, 1'b0);
        sendByte(8'h47, 1'b1);
        sendByte(8'h00, 1'b0);
        flush();
        checkVal("sf_b99_err", 32'(outQ[99].err), 0);
        checkVal("sf_realign_err", 32'(outQ[100].err), 1);
        checkVal("sf_realign_data", 32'(outQ[100].d), 32'hB8);
        checkVal("sf_realign_gs", 32'(outQ[100].gs), 1);
        checkVal("sf_realign_lock", 32'(outQ[100].lk), 1);
        checkVal("sf_realign_b1", 32'(outQ[101].d), 32'h03);
        checkVal("sf_realign_b2", 32'(outQ[102].d), 32'hF6);
        checkVal("sf_miss_err", 32'(outQ[304].err), 1);
        checkVal("sf_miss_lock", 32'(outQ[304].lk), 0);
        checkVal("sf_miss_data", 32'(outQ[304].d), 32'h47);
        checkVal("sf_search_data", 32'(outQ[305].d), 32'h00);
        checkVal("sf_search_lock", 32'(outQ[305].lk), 0);
        checkVal("sf_relock_data", 32'(outQ[310].d), 32'hB8);
        checkVal("sf_relock_lock", 32'(outQ[310].lk), 1);
        checkVal("sf_relock_b1", 32'(outQ[311].d), 32'h03);
        bad = 0;
        foreach (outQ[i]) if (outQ[i].err) bad++;
        checkVal("sf_err_count", 32'(bad), 2);

        // Bypass switched on mid-packet 0 and held for 9 packets.
        resetAll();
        for (int p = 0; p < 9; p++)
            for (int b = 0; b < 204; b++) begin
                if (p == 0 && b == 50) iBypass = 1'b1;
                sendByte(frameByte(b, 8'h00), b == 0);
            end
        iBypass = 1'b0;
        flush();
        checkVal("byp_b0", 32'(outQ[0].d), 32'hB8);
        checkVal("byp_b1", 32'(outQ[1].d), 32'h03);
        checkVal("byp_b50", 32'(outQ[50].d), 32'h00);
        checkVal("byp_b100", 32'(outQ[100].d), 32'h00);
        checkVal("byp_p1_b1", 32'(outQ[205].d), 32'h00);
        checkVal("byp_p8_sync", 32'(outQ[8*204].d), 32'h47);
        checkVal("byp_p8_gs", 32'(outQ[8*204].gs), 1);
        cnt = 0;
        foreach (outQ[i]) if (outQ[i].gs) cnt++;
        checkVal("byp_gs_count", 32'(cnt), 2);

        // Reset in the middle of a packet.
        resetAll();
        sendByte(8'h47, 1'b1);
        for (int i = 1; i < 50; i++) sendByte(8'h00, 1'b0);
        iData = 8'h47; iPSync = 1'b1; iValid = 1'b1; iRst = 1'b1;
        @(posedge iClk); #1;
        checkVal("mrst_oData", 32'(oData), 0);
        checkVal("mrst_oValid", 32'(oValid), 0);
        checkVal("mrst_oPSync", 32'(oPSync), 0);
        checkVal("mrst_oGroupStart", 32'(oGroupStart), 0);
        checkVal("mrst_oLocked", 32'(oLocked), 0);
        checkVal("mrst_oSyncErr", 32'(oSyncErr), 0);
        iRst = 1'b0; iValid = 1'b0; iPSync = 1'b0;
        outQ.delete();
        for (int i = 0; i < 3; i++) sendByte(8'h11, 1'b0);
        sendByte(8'h47, 1'b1);
        sendByte(8'h00, 1'b0);
        flush();
        checkVal("mrst_search_data", 32'(outQ[0].d), 32'h11);
        checkVal("mrst_search_lock", 32'(outQ[0].lk), 0);
        checkVal("mrst_relock_data", 32'(outQ[3].d), 32'hB8);
        checkVal("mrst_relock_gs", 32'(outQ[3].gs), 1);
        checkVal("mrst_relock_lock", 32'(outQ[3].lk), 1);
        checkVal("mrst_relock_b1", 32'(outQ[4].d), 32'h03);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
